demux_nbit_x4_reg: RTL and testbench

DEMUX_NBIT_X4_REG -- requirements
Module: demux_nbit_x4

---
 rtl/demux_nbit_x4_reg_if.sv | 24 ++
 rtl/demux_nbit_x4_reg.sv | 39 +++
 tb/tb_demux_nbit_x4_reg.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/demux_nbit_x4_reg_if.sv
// Bundle for the 1-to-4 registered demux: routed word, select and qualifier in,
// four destination words and the one-hot destination strobe out.
interface demux_nbit_x4_reg_if #(
    parameter int BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] y;
    logic [1:0]           sel;
    logic                 in_valid;
    logic [BUS_WIDTH-1:0] a;
    logic [BUS_WIDTH-1:0] b;
    logic [BUS_WIDTH-1:0] c;
    logic [BUS_WIDTH-1:0] d;
    logic [3:0]           out_valid;

    modport master (
        output y, sel, in_valid,
        input  a, b, c, d, out_valid
    );

    modport slave (
        input  y, sel, in_valid,
        output a, b, c, d, out_valid
    );
endinterface

// File: rtl/demux_nbit_x4_reg.sv
// Routes one BUS_WIDTH word per valid cycle to one of four registered outputs.
// Latency: exactly 1 clock, sampled inputs to outputs.
// Backpressure: none; every valid cycle is accepted, invalid cycles are ignored.
module demux_nbit_x4_reg #(
    parameter int BUS_WIDTH       = 8,
    parameter bit HOLD_UNSELECTED = 1'b0
) (
    input logic               clk,
    input logic               rst,
    demux_nbit_x4_reg_if.slave bus
);
    logic [BUS_WIDTH-1:0] data_q [4];
    logic [3:0]           vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset wins over a concurrent valid word, including held values.
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
            vld_q <= 4'b0000;
        end else begin
            vld_q <= bus.in_valid ? (4'b0001 << bus.sel) : 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (bus.in_valid && (bus.sel == 2'(i))) begin
                    data_q[i] <= bus.y;
                end else if (!HOLD_UNSELECTED) begin
                    data_q[i] <= '0;
                end
            end
        end
    end

    assign bus.a         = data_q[0];
    assign bus.b         = data_q[1];
    assign bus.c         = data_q[2];
    assign bus.d         = data_q[3];
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_demux_nbit_x4_reg.sv
// Directed bench for demux_nbit_x4_reg: one instance per HOLD_UNSELECTED mode,
// both driven with the same stimulus and checked against their own expectations.
module tb_demux_nbit_x4_reg;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    demux_nbit_x4_reg_if #(.BUS_WIDTH(8)) if0 ();
    demux_nbit_x4_reg_if #(.BUS_WIDTH(8)) if1 ();

    demux_nbit_x4_reg #(.BUS_WIDTH(8), .HOLD_UNSELECTED(1'b0)) u_zero (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    demux_nbit_x4_reg #(.BUS_WIDTH(8), .HOLD_UNSELECTED(1'b1)) u_hold (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input int which, input string tag,
                           input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] ec, input logic [7:0] ed,
                           input logic [3:0] ev);
        string m;
        m = (which == 0) ? "zero" : "hold";
        if (which == 0) begin
            chk($sformatf("%s/%s/a", tag, m), if0.a, ea);
            chk($sformatf("%s/%s/b", tag, m), if0.b, eb);
            chk($sformatf("%s/%s/c", tag, m), if0.c, ec);
            chk($sformatf("%s/%s/d", tag, m), if0.d, ed);
            chk($sformatf("%s/%s/ov", tag, m), {4'b0, if0.out_valid}, {4'b0, ev});
        end else begin
            chk($sformatf("%s/%s/a", tag, m), if1.a, ea);
            chk($sformatf("%s/%s/b", tag, m), if1.b, eb);
            chk($sformatf("%s/%s/c", tag, m), if1.c, ec);
            chk($sformatf("%s/%s/d", tag, m), if1.d, ed);
            chk($sformatf("%s/%s/ov", tag, m), {4'b0, if1.out_valid}, {4'b0, ev});
        end
    endtask

    // Apply one cycle of inputs to both instances, then sample 1 ns after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s, input logic [7:0] yy);
        rst          = r;
        if0.in_valid = v;
        if0.sel      = s;
        if0.y        = yy;
        if1.in_valid = v;
        if1.sel      = s;
        if1.y        = yy;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] m0 [4];
    logic [7:0] m1 [4];
    logic [3:0] mv;

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset held for two edges with a valid word pending.
        step(1'b1, 1'b1, 2'd2, 8'hFF);
        chk_dut(0, "rst1", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_dut(1, "rst1", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        step(1'b1, 1'b1, 2'd2, 8'hFF);
        chk_dut(0, "rst2", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_dut(1, "rst2", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // Sweep all four destinations on consecutive valid cycles.
        step(1'b0, 1'b1, 2'd0, 8'h11);
        chk_dut(0, "sw0", 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001);
        chk_dut(1, "sw0", 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001);
        step(1'b0, 1'b1, 2'd1, 8'h22);
        chk_dut(0, "sw1", 8'h00, 8'h22, 8'h00, 8'h00, 4'b0010);
        chk_dut(1, "sw1", 8'h11, 8'h22, 8'h00, 8'h00, 4'b0010);
        step(1'b0, 1'b1, 2'd2, 8'h33);
        chk_dut(0, "sw2", 8'h00, 8'h00, 8'h33, 8'h00, 4'b0100);
        chk_dut(1, "sw2", 8'h11, 8'h22, 8'h33, 8'h00, 4'b0100);
        step(1'b0, 1'b1, 2'd3, 8'h44);
        chk_dut(0, "sw3", 8'h00, 8'h00, 8'h00, 8'h44, 4'b1000);
        chk_dut(1, "sw3", 8'h11, 8'h22, 8'h33, 8'h44, 4'b1000);

        // Invalid cycle: sel and y must be ignored.
        step(1'b0, 1'b0, 2'd1, 8'hA5);
        chk_dut(0, "inv", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_dut(1, "inv", 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000);

        // Load a, then reset concurrent with a valid word for d.
        step(1'b0, 1'b1, 2'd0, 8'h5A);
        chk_dut(0, "ld5a", 8'h5A, 8'h00, 8'h00, 8'h00, 4'b0001);
        chk_dut(1, "ld5a", 8'h5A, 8'h22, 8'h33, 8'h44, 4'b0001);
        step(1'b1, 1'b1, 2'd3, 8'h77);
        chk_dut(0, "midrst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
        chk_dut(1, "midrst", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

        // First valid after release, then the same destination twice in a row.
        step(1'b0, 1'b1, 2'd3, 8'h77);
        chk_dut(0, "post", 8'h00, 8'h00, 8'h00, 8'h77, 4'b1000);
        chk_dut(1, "post", 8'h00, 8'h00, 8'h00, 8'h77, 4'b1000);
        step(1'b0, 1'b1, 2'd3, 8'h80);
        chk_dut(0, "same", 8'h00, 8'h00, 8'h00, 8'h80, 4'b1000);
        chk_dut(1, "same", 8'h00, 8'h00, 8'h00, 8'h80, 4'b1000);

        // Random valid run against a reference model of both modes.
        m1[0] = 8'h00; m1[1] = 8'h00; m1[2] = 8'h00; m1[3] = 8'h80;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] rs;
            logic [7:0] ry;
            rs = 2'($urandom_range(3, 0));
            ry = 8'($urandom_range(255, 0));
            for (int i = 0; i < 4; i++) begin
                m0[i] = (i == int'(rs)) ? ry : 8'h00;
                if (i == int'(rs)) m1[i] = ry;
            end
            mv = 4'b0000;
            mv[rs] = 1'b1;
            step(1'b0, 1'b1, rs, ry);
            chk_dut(0, $sformatf("rnd%0d", k), m0[0], m0[1], m0[2], m0[3], mv);
            chk_dut(1, $sformatf("rnd%0d", k), m1[0], m1[1], m1[2], m1[3], mv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
